link_rx_buffer: RTL and testbench

Receive-side elastic buffer between an internode link's rx parallel output and one inject port of the switch; one instance per direction (xpos..zneg) inside node.
Captures valid flits arriving from the link and holds them in a FIFO. Presents them to the switch through the inject/inject_receive/InjectSlotAvail handshake.
Returns one credit pulse per flit delivered, so the far-side sender can limit in-flight traffic to the buffer capacity.

---
 rtl/link_rx_buffer_if.sv | 39 +++
 rtl/link_rx_buffer.sv | 146 ++++++++++++++
 tb/tb_link_rx_buffer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/link_rx_buffer_if.sv
// rtl/link_rx_buffer_if.sv - link rx to switch inject port bundle
// Purpose: groups the link receive inputs, the switch inject handshake and
// the buffer status outputs of link_rx_buffer.
// Signals:
//   rx_par_data     flit from link, MSB is the link valid flag
//   rx_ready        link locked/aligned; data ignored while low
//   inject          head flit to the switch (MSB mirrors inject_receive)
//   inject_receive  head flit valid
//   InjectSlotAvail switch accepts a flit this cycle
//   credit_return   one-cycle pulse per flit handed to the switch
//   occupancy       flits held, RAM plus head register
//   almost_full     free slots <= threshold
//   overflow_cnt    saturating count of flits dropped while full
// Modports: master drives the link/switch side, slave is the buffer.
interface link_rx_buffer_if #(
   parameter int DataWidth = 256,
   parameter int AddrWidth = 7,
   parameter int CntWidth  = 8
);
   logic [DataWidth-1:0] rx_par_data;
   logic                 rx_ready;
   logic [DataWidth-1:0] inject;
   logic                 inject_receive;
   logic                 InjectSlotAvail;
   logic                 credit_return;
   logic [AddrWidth:0]   occupancy;
   logic                 almost_full;
   logic [CntWidth-1:0]  overflow_cnt;

   modport master (
      output rx_par_data, rx_ready, InjectSlotAvail,
      input  inject, inject_receive, credit_return, occupancy, almost_full, overflow_cnt
   );

   modport slave (
      input  rx_par_data, rx_ready, InjectSlotAvail,
      output inject, inject_receive, credit_return, occupancy, almost_full, overflow_cnt
   );
endinterface

// File: rtl/link_rx_buffer.sv
// rtl/link_rx_buffer.sv - receive-side elastic buffer from link rx to switch inject port
// Purpose: captures valid link flits into a FIFO made of a circular RAM of
// FIFODepth-1 entries plus one output (head) register, presents the head to
// the switch and returns one credit per flit delivered.
// Ports:
//   clk  core clock
//   rst  asynchronous active-high reset
//   bus  link_rx_buffer_if.slave (rx flits in, inject handshake and status out)
module link_rx_buffer #(
   parameter int DataWidth        = 256,
   parameter int FIFODepth        = 128,
   parameter int AddrWidth        = 7,
   parameter int AlmostFullThresh = 8,
   parameter int CntWidth         = 8
) (
   input  logic             clk,
   input  logic             rst,
   link_rx_buffer_if.slave  bus
);

   localparam logic [AddrWidth:0]   OccFull  = (AddrWidth+1)'(FIFODepth);
   localparam logic [AddrWidth:0]   AfThresh = (AddrWidth+1)'(AlmostFullThresh);
   localparam logic [AddrWidth:0]   OccOne   = (AddrWidth+1)'(1);
   localparam logic [AddrWidth-1:0] PtrLast  = AddrWidth'(FIFODepth-2);
   localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);
   localparam logic [CntWidth-1:0]  CntOne   = CntWidth'(1);
   localparam logic [DataWidth-1:0] ValidBit = {1'b1, {(DataWidth-1){1'b0}}};

   // RAM holds everything behind the head; contents need no reset
   logic [DataWidth-1:0] mem [0:FIFODepth-2];

   logic [DataWidth-1:0] head_q, head_d;
   logic                 head_vld_q, head_vld_d;
   logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
   logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrWidth-1:0] ram_cnt_q, ram_cnt_d;
   logic [AddrWidth:0]   occ_q, occ_d;
   logic                 af_q, af_d;
   logic [CntWidth-1:0]  ovf_q, ovf_d;
   logic                 credit_q, credit_d;

   logic                 wr, rd, full, wr_acc, ram_empty;
   logic                 to_head, ram_push, ram_pop;
   logic [DataWidth-1:0] wr_flit;

   // RAM depth is not a power of two, so pointers wrap explicitly
   function automatic logic [AddrWidth-1:0] ptr_inc(input logic [AddrWidth-1:0] p);
      return (p == PtrLast) ? '0 : p + AddrOne;
   endfunction

   always_comb begin
      wr        = bus.rx_ready & bus.rx_par_data[DataWidth-1];
      rd        = head_vld_q & bus.InjectSlotAvail;
      full      = (occ_q == OccFull);
      // a read on the same edge frees the slot the full-time write needs
      wr_acc    = wr & (~full | rd);
      wr_flit   = bus.rx_par_data | ValidBit;
      ram_empty = (ram_cnt_q == '0);
      // new flit skips the RAM when nothing is queued ahead of it
      to_head   = wr_acc & (~head_vld_q | (rd & ram_empty));
      ram_push  = wr_acc & ~to_head;
      ram_pop   = rd & ~ram_empty;
   end

   always_comb begin
      head_d     = head_q;
      head_vld_d = head_vld_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      ram_cnt_d  = ram_cnt_q;
      occ_d      = occ_q;
      ovf_d      = ovf_q;
      credit_d   = rd;

      if (ram_pop) begin
         head_d   = mem[rd_ptr_q];
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else if (to_head) begin
         head_d     = wr_flit;
         head_vld_d = 1'b1;
      end else if (rd) begin
         head_d     = '0;
         head_vld_d = 1'b0;
      end

      if (ram_push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end

      case ({ram_push, ram_pop})
         2'b10:   ram_cnt_d = ram_cnt_q + AddrOne;
         2'b01:   ram_cnt_d = ram_cnt_q - AddrOne;
         default: ram_cnt_d = ram_cnt_q;
      endcase

      case ({wr_acc, rd})
         2'b10:   occ_d = occ_q + OccOne;
         2'b01:   occ_d = occ_q - OccOne;
         default: occ_d = occ_q;
      endcase

      if (wr & ~wr_acc & (ovf_q != '1)) begin
         ovf_d = ovf_q + CntOne;
      end

      af_d = ((OccFull - occ_d) <= AfThresh);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q     <= '0;
         head_vld_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         ram_cnt_q  <= '0;
         occ_q      <= '0;
         af_q       <= 1'b0;
         ovf_q      <= '0;
         credit_q   <= 1'b0;
      end else begin
         head_q     <= head_d;
         head_vld_q <= head_vld_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         ram_cnt_q  <= ram_cnt_d;
         occ_q      <= occ_d;
         af_q       <= af_d;
         ovf_q      <= ovf_d;
         credit_q   <= credit_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_push) begin
         mem[wr_ptr_q] <= wr_flit;
      end
   end

   assign bus.inject         = head_q;
   assign bus.inject_receive = head_vld_q;
   assign bus.credit_return  = credit_q;
   assign bus.occupancy      = occ_q;
   assign bus.almost_full    = af_q;
   assign bus.overflow_cnt   = ovf_q;

endmodule

// File: tb/tb_link_rx_buffer.sv
// tb/tb_link_rx_buffer.sv - scoreboard bench for link_rx_buffer
module tb_link_rx_buffer;
   localparam int DW    = 256;
   localparam int DEPTH = 128;
   localparam int AW    = 7;
   localparam int THR   = 8;
   localparam int CW    = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [DW-1:0] exp_q[$];
   int            m_ovf = 0;
   logic          m_credit = 1'b0;

   link_rx_buffer_if #(.DataWidth(DW), .AddrWidth(AW), .CntWidth(CW)) bus_if ();

   link_rx_buffer #(
      .DataWidth(DW), .FIFODepth(DEPTH), .AddrWidth(AW),
      .AlmostFullThresh(THR), .CntWidth(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // one clock cycle of stimulus, returns 1 time unit after the edge
   task automatic cyc(input logic rdy, input logic vld, input int payload, input logic avail);
      bus_if.rx_ready        = rdy;
      bus_if.rx_par_data     = {vld, (DW-1)'(payload)};
      bus_if.InjectSlotAvail = avail;
      @(posedge clk);
      #1;
   endtask

   // Monitor/scoreboard: at each falling edge check the DUT against the
   // reference queue, then advance the reference by the coming edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            m_ovf    = 0;
            m_credit = 1'b0;
         end else begin
            logic rd, wr, full;
            chk("inject_receive", bus_if.inject_receive, exp_q.size() > 0);
            chk("occupancy", bus_if.occupancy, exp_q.size());
            chk("almost_full", bus_if.almost_full, (DEPTH - exp_q.size()) <= THR);
            chk("overflow_cnt", bus_if.overflow_cnt, m_ovf);
            chk("credit_return", bus_if.credit_return, m_credit);
            if (exp_q.size() > 0) chk("inject_head", bus_if.inject, exp_q[0]);
            else                  chk("inject_idle", bus_if.inject, '0);

            rd   = (exp_q.size() > 0) && bus_if.InjectSlotAvail;
            wr   = bus_if.rx_ready && bus_if.rx_par_data[DW-1];
            full = (exp_q.size() == DEPTH);
            if (rd) void'(exp_q.pop_front());
            if (wr) begin
               if (full && !rd) begin
                  if (m_ovf < 255) m_ovf++;
               end else begin
                  exp_q.push_back(bus_if.rx_par_data);
               end
            end
            m_credit = rd;
         end
      end
   end

   initial begin
      bus_if.rx_ready        = 1'b0;
      bus_if.rx_par_data     = '0;
      bus_if.InjectSlotAvail = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_inject", bus_if.inject, '0);
      chk("rst_inject_receive", bus_if.inject_receive, 1'b0);
      chk("rst_credit", bus_if.credit_return, 1'b0);
      chk("rst_occupancy", bus_if.occupancy, 0);
      chk("rst_almost_full", bus_if.almost_full, 1'b0);
      chk("rst_overflow", bus_if.overflow_cnt, 0);
      rst = 1'b0;
      repeat (6) cyc(1'b0, 1'b0, 0, 1'b0);

      // single flit: 1-cycle latency, credit one cycle after the read
      cyc(1'b1, 1'b1, 'hA5, 1'b1);
      chk("single_valid", bus_if.inject_receive, 1'b1);
      chk("single_payload", bus_if.inject[7:0], 8'hA5);
      chk("single_occ1", bus_if.occupancy, 1);
      cyc(1'b1, 1'b0, 0, 1'b1);
      chk("single_credit", bus_if.credit_return, 1'b1);
      chk("single_occ0", bus_if.occupancy, 0);
      cyc(1'b1, 1'b0, 0, 1'b1);
      chk("single_credit_end", bus_if.credit_return, 1'b0);

      // fill to capacity, then three dropped flits
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, i, 1'b0);
      chk("fill_occ", bus_if.occupancy, DEPTH);
      chk("fill_af", bus_if.almost_full, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 200 + i, 1'b0);
      chk("ovf_3", bus_if.overflow_cnt, 3);

      // full with simultaneous read and write
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 300 + i, 1'b1);
      chk("full_rw_occ", bus_if.occupancy, DEPTH);
      chk("full_rw_ovf", bus_if.overflow_cnt, 3);

      // drain everything
      for (int i = 0; i < DEPTH + 4; i++) cyc(1'b1, 1'b0, 0, 1'b1);

      // streaming with toggling slot availability and some invalid flits
      for (int i = 0; i < 40; i++) cyc(1'b1, (i % 7) != 3, 400 + i, (i % 2) == 0);
      for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 0, 1'b1);

      // link not ready: valid-looking flits ignored
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 500 + i, 1'b0);
      chk("rxnr_occ", bus_if.occupancy, 0);

      // asynchronous reset with 50 flits buffered
      for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, 600 + i, 1'b0);
      chk("pre_rst_occ", bus_if.occupancy, 50);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_inject", bus_if.inject, '0);
      chk("arst_inject_receive", bus_if.inject_receive, 1'b0);
      chk("arst_credit", bus_if.credit_return, 1'b0);
      chk("arst_occupancy", bus_if.occupancy, 0);
      chk("arst_almost_full", bus_if.almost_full, 1'b0);
      chk("arst_overflow", bus_if.overflow_cnt, 0);
      bus_if.rx_ready = 1'b0;
      bus_if.InjectSlotAvail = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 0, 1'b1);

      chk("final_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
